lcd_bus_feeder: RTL and testbench
=================================

LCD_BUS_FEEDER -- requirements
Module: lcd_bus_feeder

Interface
REQ-001: Parameter WR_LOW, default 2, sets the number of clk cycles lcd_wr_n is held low per bus write; legal range 1-15.
REQ-002: Parameter WR_HIGH, default 2, sets the number of clk cycles lcd_wr_n is held high after each low phase; legal range 1-15.
REQ-003: Parameter PIXELS_PER_FRAME, default 153600 (480x320), is the expected pixel count per field.
REQ-004: clk  in  1  single system clock; all logic on posedge clk.
REQ-005: reset  in  1  asynchronous, active-low reset.
REQ-006: stream_en  in  1  1 = stream pixels from the video memory; 0 = serve the command port.
REQ-007: lcd_wait, lcd_newfield  in  1 each  status from the video memory LCD read port.
REQ-008: lcd_red, lcd_green, lcd_blue  in  8 each  current LCD pixel from the video memory.
REQ-009: lcd_next_pixel  out  1  one-cycle pulse that advances the video memory LCD read address.
REQ-010: cmd_valid, cmd_rs  in  1 each; cmd_data  in  16; cmd_ready  out  1  command/data port for panel init.
REQ-011: lcd_db  out  16; lcd_wr_n, lcd_rs, lcd_cs_n  out  1 each  8080-style parallel panel bus.
REQ-012: frame_done  out  1  one-cycle pulse per completed field; overrun  out  1  sticky pixel-count error flag.

Function
REQ-013: The state machine SHALL have the states IDLE, CMD_WR, MEMWR_CMD, PIX_WAIT, PIX_WR, ADVANCE, SETTLE1 and SETTLE2.
REQ-014: Every bus write SHALL drive lcd_db, lcd_rs and lcd_cs_n=0 in the first cycle, hold lcd_wr_n=0 for WR_LOW cycles, then hold lcd_wr_n=1 for WR_HIGH cycles, with lcd_db and lcd_rs stable for all WR_LOW+WR_HIGH cycles.
REQ-015: In IDLE, cmd_ready SHALL be 1 only when stream_en=0; a write SHALL be accepted when cmd_valid&cmd_ready, and that write SHALL occur in CMD_WR using lcd_rs=cmd_rs and lcd_db=cmd_data.
REQ-016: cmd_ready SHALL be 0 in every state other than IDLE.
REQ-017: IDLE with stream_en=1 SHALL go to MEMWR_CMD, which SHALL write 0x002C with lcd_rs=0 and then go to PIX_WAIT with the pixel counter cleared.
REQ-018: PIX_WAIT SHALL stall while lcd_wait=1; when lcd_wait=0 it SHALL latch lcd_db={lcd_red[7:3],lcd_green[7:2],lcd_blue[7:3]} with lcd_rs=1 and enter PIX_WR.
REQ-019: After the PIX_WR write completes, ADVANCE SHALL assert lcd_next_pixel for exactly one cycle and increment the 18-bit pixel counter.
REQ-020: SETTLE1 and SETTLE2 SHALL follow ADVANCE to cover the two-cycle read latency; pixel data SHALL NOT be sampled before SETTLE2 completes.
REQ-021: At the end of SETTLE2, if lcd_newfield=1: pulse frame_done, set overrun if the counter != PIXELS_PER_FRAME, and go to MEMWR_CMD (or to IDLE if stream_en=0).
REQ-022: At the end of SETTLE2, if lcd_newfield=0 and stream_en=1, go to PIX_WAIT.
REQ-023: At the end of SETTLE2, if lcd_newfield=0 and stream_en=0, go to IDLE with lcd_cs_n=1.
REQ-024: If the pixel counter reaches PIXELS_PER_FRAME+1 without lcd_newfield, overrun SHALL set and the counter SHALL saturate; streaming SHALL continue.
REQ-025: A stream_en change SHALL never truncate a bus write in progress; it takes effect only in IDLE or SETTLE2.
REQ-026: lcd_next_pixel SHALL never be asserted in two consecutive cycles and SHALL never be asserted while lcd_wait=1.
REQ-027: overrun SHALL clear only on reset.
REQ-028: lcd_cs_n SHALL be 1 in IDLE and 0 in all other states.

Reset
REQ-029: Reset low SHALL immediately force state IDLE and lcd_db=0, lcd_wr_n=1, lcd_rs=1, lcd_cs_n=1, lcd_next_pixel=0, cmd_ready=0, frame_done=0, overrun=0, pixel counter=0.
REQ-030: Reset asserted mid-write SHALL abort the write with lcd_wr_n=1 on the same edge; after release, the first cycle SHALL be IDLE.

Verification
REQ-031: stream_en=0, cmd {rs=0, data=0x0011} -> one write with lcd_rs=0, lcd_db=0x0011, lcd_wr_n low for 2 cycles then high for 2; cmd_ready=0 for 4 cycles.
REQ-032: stream_en=1, pixel (0xFF,0x00,0x80) -> write of 0x002C (rs=0), then 0xF810 (rs=1), then one lcd_next_pixel pulse 4 cycles after the pixel write begins.
REQ-033: lcd_wait held at 1 for 20 cycles during PIX_WAIT -> no write and no lcd_next_pixel until 1 cycle after lcd_wait falls.
REQ-034: Field of 153600 pixels followed by lcd_newfield -> frame_done pulse, overrun=0, next write 0x002C; repeat with 100 pixels -> overrun=1 and it stays set.
REQ-035: Reset asserted during the lcd_wr_n low phase -> all outputs at their reset values immediately; after release, stream_en=1 restarts with 0x002C.
REQ-036: stream_en dropped mid-pixel-write -> the write completes, lcd_next_pixel pulses, the block goes to IDLE, and cmd_ready=1.

Source files
------------

// File: rtl/lcd_bus_feeder.sv
// rtl/lcd_bus_feeder.sv - 8080-style LCD bus writer fed from video memory or a command port
module lcd_bus_feeder #(
    parameter int WR_LOW           = 2,
    parameter int WR_HIGH          = 2,
    parameter int PIXELS_PER_FRAME = 153600
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stream_en,
    input  logic        lcd_wait,
    input  logic        lcd_newfield,
    input  logic [7:0]  lcd_red,
    input  logic [7:0]  lcd_green,
    input  logic [7:0]  lcd_blue,
    output logic        lcd_next_pixel,
    input  logic        cmd_valid,
    input  logic        cmd_rs,
    input  logic [15:0] cmd_data,
    output logic        cmd_ready,
    output logic [15:0] lcd_db,
    output logic        lcd_wr_n,
    output logic        lcd_rs,
    output logic        lcd_cs_n,
    output logic        frame_done,
    output logic        overrun
);

    typedef enum logic [2:0] {
        IDLE, CMD_WR, MEMWR_CMD, PIX_WAIT, PIX_WR, ADVANCE, SETTLE1, SETTLE2
    } state_t;

    localparam logic [4:0]  WR_LOW_C  = 5'(WR_LOW);
    localparam logic [4:0]  WR_LAST_C = 5'(WR_LOW + WR_HIGH - 1);
    localparam logic [17:0] PPF_C     = 18'(PIXELS_PER_FRAME);
    localparam logic [17:0] PIX_SAT_C = 18'(PIXELS_PER_FRAME + 1);
    localparam logic [15:0] MEMWR_OP  = 16'h002C;

    state_t      state_q, state_d;
    logic        alive_q;
    logic [4:0]  wr_cnt_q;
    logic [17:0] pix_cnt_q;
    logic        in_write, wr_last, wr_n_d;
    logic        bus_load, rs_d;
    logic [15:0] db_d;
    logic        pix_clr, pix_inc, frame_pulse, overrun_set;
    logic        unused_pix_bits;

    assign unused_pix_bits = ^{lcd_red[2:0], lcd_green[1:0], lcd_blue[2:0]};

    assign in_write = (state_q == CMD_WR) || (state_q == MEMWR_CMD) || (state_q == PIX_WR);
    assign wr_last  = (wr_cnt_q == WR_LAST_C);

    // alive_q keeps cmd_ready low while reset is held, even though state sits in IDLE
    assign cmd_ready      = alive_q && (state_q == IDLE) && !stream_en;
    assign lcd_next_pixel = (state_q == ADVANCE) && !lcd_wait;

    always_comb begin
        state_d     = state_q;
        bus_load    = 1'b0;
        db_d        = lcd_db;
        rs_d        = lcd_rs;
        pix_clr     = 1'b0;
        pix_inc     = 1'b0;
        frame_pulse = 1'b0;
        overrun_set = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    state_d  = CMD_WR;
                    bus_load = 1'b1;
                    db_d     = cmd_data;
                    rs_d     = cmd_rs;
                end else if (stream_en) begin
                    state_d  = MEMWR_CMD;
                    bus_load = 1'b1;
                    db_d     = MEMWR_OP;
                    rs_d     = 1'b0;
                end
            end
            CMD_WR: if (wr_last) state_d = IDLE;
            MEMWR_CMD: begin
                if (wr_last) begin
                    state_d = PIX_WAIT;
                    pix_clr = 1'b1;
                end
            end
            PIX_WAIT: begin
                if (!lcd_wait) begin
                    state_d  = PIX_WR;
                    bus_load = 1'b1;
                    db_d     = {lcd_red[7:3], lcd_green[7:2], lcd_blue[7:3]};
                    rs_d     = 1'b1;
                end
            end
            PIX_WR: if (wr_last) state_d = ADVANCE;
            ADVANCE: begin
                if (!lcd_wait) begin
                    state_d     = SETTLE1;
                    pix_inc     = 1'b1;
                    overrun_set = (pix_cnt_q == PPF_C);
                end
            end
            SETTLE1: state_d = SETTLE2;
            SETTLE2: begin
                if (lcd_newfield) begin
                    frame_pulse = 1'b1;
                    overrun_set = (pix_cnt_q != PPF_C);
                end
                if (!stream_en) begin
                    state_d = IDLE;
                end else if (lcd_newfield) begin
                    state_d  = MEMWR_CMD;
                    bus_load = 1'b1;
                    db_d     = MEMWR_OP;
                    rs_d     = 1'b0;
                end else begin
                    state_d = PIX_WAIT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // wr_n is registered so the strobe is glitch-free; low for the first WR_LOW cycles of a write
    always_comb begin
        wr_n_d = 1'b1;
        if (bus_load)
            wr_n_d = 1'b0;
        else if (in_write && !wr_last && ((wr_cnt_q + 5'd1) < WR_LOW_C))
            wr_n_d = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            alive_q    <= 1'b0;
            wr_cnt_q   <= '0;
            pix_cnt_q  <= '0;
            lcd_db     <= '0;
            lcd_rs     <= 1'b1;
            lcd_wr_n   <= 1'b1;
            lcd_cs_n   <= 1'b1;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state_q    <= state_d;
            alive_q    <= 1'b1;
            lcd_wr_n   <= wr_n_d;
            lcd_cs_n   <= (state_d == IDLE);
            frame_done <= frame_pulse;
            if (bus_load) begin
                lcd_db   <= db_d;
                lcd_rs   <= rs_d;
                wr_cnt_q <= '0;
            end else if (in_write) begin
                wr_cnt_q <= wr_cnt_q + 5'd1;
            end
            if (pix_clr)
                pix_cnt_q <= '0;
            else if (pix_inc && (pix_cnt_q != PIX_SAT_C))
                pix_cnt_q <= pix_cnt_q + 18'd1;
            if (overrun_set)
                overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_lcd_bus_feeder.sv
// tb/tb_lcd_bus_feeder.sv - self-checking bench for lcd_bus_feeder
module tb_lcd_bus_feeder;
    localparam int WR_LOW  = 2;
    localparam int WR_HIGH = 2;
    localparam int PPF     = 8;
    localparam int NF      = 5;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stream_en = 1'b0;
    logic        lcd_wait = 1'b0;
    logic        lcd_newfield = 1'b0;
    logic [7:0]  lcd_red, lcd_green, lcd_blue;
    logic        lcd_next_pixel;
    logic        cmd_valid = 1'b0;
    logic        cmd_rs = 1'b0;
    logic [15:0] cmd_data = 16'h0;
    logic        cmd_ready;
    logic [15:0] lcd_db;
    logic        lcd_wr_n, lcd_rs, lcd_cs_n, frame_done, overrun;

    lcd_bus_feeder #(.WR_LOW(WR_LOW), .WR_HIGH(WR_HIGH), .PIXELS_PER_FRAME(PPF)) dut (
        .clk(clk), .reset(reset), .stream_en(stream_en), .lcd_wait(lcd_wait),
        .lcd_newfield(lcd_newfield), .lcd_red(lcd_red), .lcd_green(lcd_green),
        .lcd_blue(lcd_blue), .lcd_next_pixel(lcd_next_pixel), .cmd_valid(cmd_valid),
        .cmd_rs(cmd_rs), .cmd_data(cmd_data), .cmd_ready(cmd_ready), .lcd_db(lcd_db),
        .lcd_wr_n(lcd_wr_n), .lcd_rs(lcd_rs), .lcd_cs_n(lcd_cs_n),
        .frame_done(frame_done), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;

    // video memory model: flat pixel array, fields of lengths flen[]
    logic [23:0] pix_mem [512];
    int flen [NF] = '{PPF, PPF, 3, PPF, PPF + 3};
    int addr = 0, idx = 0, fld = 0;
    assign lcd_red   = pix_mem[addr][23:16];
    assign lcd_green = pix_mem[addr][15:8];
    assign lcd_blue  = pix_mem[addr][7:0];

    bit wait_hold = 1'b0, wait_rand = 1'b0;
    always @(posedge clk) begin
        #2;
        lcd_wait = wait_hold || (wait_rand && ($urandom_range(0, 3) == 0));
    end

    // bus monitor
    int cyc = 0, wait_fall_cyc = 0, np_cnt = 0, fd_cnt = 0, low_len = 0;
    int bad_low = 0, bad_stable = 0, np_wait_bad = 0, np_back_bad = 0;
    bit in_low = 1'b0, prev_np = 1'b0, prev_wait = 1'b0, prev_wr_n = 1'b1;
    logic [16:0] wq [$];
    int wstart [$];
    int np_cyc [$];
    logic fd_ov [$];

    always @(negedge clk) begin
        cyc++;
        if (prev_wait && !lcd_wait) wait_fall_cyc = cyc;
        prev_wait = lcd_wait;
        if (!reset) begin
            in_low  = 1'b0;
            prev_np = 1'b0;
        end else begin
            if (!lcd_wr_n && prev_wr_n) begin
                wq.push_back({lcd_rs, lcd_db});
                wstart.push_back(cyc);
                low_len = 1;
                in_low  = 1'b1;
            end else if (!lcd_wr_n && in_low) begin
                low_len++;
                if ({lcd_rs, lcd_db} !== wq[$]) bad_stable++;
            end else if (lcd_wr_n && in_low) begin
                in_low = 1'b0;
                if (low_len != WR_LOW) bad_low++;
            end
            if (lcd_next_pixel) begin
                np_cnt++;
                np_cyc.push_back(cyc);
                if (lcd_wait) np_wait_bad++;
                if (prev_np) np_back_bad++;
                addr = (addr + 1) % 512;
                lcd_newfield = 1'b0;
                if (fld < NF) begin
                    idx++;
                    if (idx == flen[fld]) begin
                        idx = 0;
                        fld++;
                        lcd_newfield = 1'b1;
                    end
                end
            end
            prev_np = lcd_next_pixel;
            if (frame_done) begin
                fd_cnt++;
                fd_ov.push_back(overrun);
            end
        end
        prev_wr_n = lcd_wr_n;
    end

    function automatic logic [15:0] rgb565(input logic [23:0] p);
        int v;
        v = (((int'(p) >> 19) & 31) << 11) | (((int'(p) >> 10) & 63) << 5) | ((int'(p) >> 3) & 31);
        return 16'(v);
    endfunction

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_reset_outputs();
        chk("rst_db", 32'(lcd_db), 32'h0);
        chk("rst_wr_n", 32'(lcd_wr_n), 32'd1);
        chk("rst_rs", 32'(lcd_rs), 32'd1);
        chk("rst_cs_n", 32'(lcd_cs_n), 32'd1);
        chk("rst_next_pixel", 32'(lcd_next_pixel), 32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
    endtask

    initial begin
        logic [16:0] c;
        logic [16:0] cexp [$];
        logic [16:0] sexp [$];
        int base, sw0, w1, wb, npb, nmin;
        logic ov;

        for (int i = 0; i < 512; i++) pix_mem[i] = 24'($urandom);
        pix_mem[0] = 24'hFF0080;

        step(); step();
        chk_reset_outputs();
        reset = 1'b1;
        step();
        chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("idle_cs_n", 32'(lcd_cs_n), 32'd1);

        // directed command write: cycle-exact strobe shape
        cmd_rs = 1'b0; cmd_data = 16'h0011; cmd_valid = 1'b1;
        cexp.push_back({1'b0, 16'h0011});
        step();
        cmd_valid = 1'b0;
        for (int k = 0; k < WR_LOW + WR_HIGH; k++) begin
            chk("cmd_wr_n", 32'(lcd_wr_n), (k < WR_LOW) ? 32'd0 : 32'd1);
            chk("cmd_rs", 32'(lcd_rs), 32'd0);
            chk("cmd_db", 32'(lcd_db), 32'h0011);
            chk("cmd_cs_n", 32'(lcd_cs_n), 32'd0);
            chk("cmd_busy_ready", 32'(cmd_ready), 32'd0);
            step();
        end
        chk("cmd_done_ready", 32'(cmd_ready), 32'd1);
        chk("cmd_done_cs_n", 32'(lcd_cs_n), 32'd1);

        // random command stream
        for (int i = 0; i < 6; i++) begin
            c = {1'($urandom), 16'($urandom)};
            for (int t = 0; t < 20 && !cmd_ready; t++) step();
            cmd_rs = c[16]; cmd_data = c[15:0]; cmd_valid = 1'b1;
            cexp.push_back(c);
            step();
            cmd_valid = 1'b0;
        end
        for (int t = 0; t < 20 && !cmd_ready; t++) step();
        chk("cmd_count", 32'(wq.size()), 32'(cexp.size()));
        for (int i = 0; i < cexp.size() && i < wq.size(); i++)
            chk("cmd_write", 32'(wq[i]), 32'(cexp[i]));

        // expected streamed write sequence: per field a 0x002C then every pixel
        base = 0;
        for (int f = 0; f <= NF; f++) begin
            sexp.push_back({1'b0, 16'h002C});
            for (int i = 0; i < ((f == NF) ? 8 : flen[f]); i++)
                sexp.push_back({1'b1, rgb565(pix_mem[base + i])});
            if (f < NF) base += flen[f];
        end

        // stream start with lcd_wait held
        sw0 = wq.size();
        wait_hold = 1'b1;
        stream_en = 1'b1;
        repeat (25) step();
        chk("hold_writes", 32'(wq.size() - sw0), 32'd1);
        chk("hold_np", 32'(np_cnt), 32'd0);
        wait_hold = 1'b0;
        for (int t = 0; t < 50 && wq.size() < sw0 + 2; t++) step();
        chk("pix_write_seen", 32'(wq.size() >= sw0 + 2), 32'd1);
        if (wq.size() >= sw0 + 2)
            chk("wait_to_write", 32'(wstart[sw0 + 1] - wait_fall_cyc), 32'd1);
        for (int t = 0; t < 50 && np_cnt < 1; t++) step();
        chk("first_np_seen", 32'(np_cnt >= 1), 32'd1);
        if (np_cnt >= 1 && wq.size() >= sw0 + 2)
            chk("np_latency", 32'(np_cyc[0] - wstart[sw0 + 1]), 32'(WR_LOW + WR_HIGH));
        wait_rand = 1'b1;

        for (int t = 0; t < 4000 && fd_cnt < NF; t++) step();
        chk("frame_count", 32'(fd_cnt), 32'(NF));
        ov = 1'b0;
        for (int f = 0; f < NF && f < fd_ov.size(); f++) begin
            ov = ov | (flen[f] != PPF);
            chk("overrun_at_frame", 32'(fd_ov[f]), 32'(ov));
        end

        // drop stream_en during a pixel write
        for (int t = 0; t < 200 && !(lcd_wr_n == 1'b0 && lcd_rs == 1'b1); t++) step();
        chk("pix_write_found", 32'(lcd_wr_n == 1'b0 && lcd_rs == 1'b1), 32'd1);
        stream_en = 1'b0;
        npb = np_cnt;
        wb  = wq.size();
        for (int t = 0; t < 100 && !cmd_ready; t++) step();
        chk("stop_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("stop_np_pulses", 32'(np_cnt - npb), 32'd1);
        chk("stop_no_new_write", 32'(wq.size()), 32'(wb));
        chk("stop_cs_n", 32'(lcd_cs_n), 32'd1);
        chk("overrun_sticky", 32'(overrun), 32'd1);

        nmin = 2;
        for (int f = 0; f < NF; f++) nmin += 1 + flen[f];
        chk("stream_write_count", 32'(wq.size() - sw0 >= nmin), 32'd1);
        for (int i = sw0; i < wq.size(); i++) begin
            if (i - sw0 < sexp.size())
                chk("stream_write", 32'(wq[i]), 32'(sexp[i - sw0]));
            else
                chk("stream_write_extra", 32'(i - sw0), 32'(sexp.size()));
        end
        chk("np_during_wait", 32'(np_wait_bad), 32'd0);
        chk("np_back_to_back", 32'(np_back_bad), 32'd0);
        chk("wr_low_length", 32'(bad_low), 32'd0);
        chk("bus_stable", 32'(bad_stable), 32'd0);

        // reset during the low phase of a write
        wait_rand = 1'b0;
        stream_en = 1'b1;
        for (int t = 0; t < 50 && lcd_wr_n; t++) step();
        chk("low_phase_found", 32'(lcd_wr_n), 32'd0);
        reset = 1'b0;
        #1;
        chk_reset_outputs();
        step(); step();
        reset = 1'b1;
        #1;
        chk("release_cs_n", 32'(lcd_cs_n), 32'd1);
        chk("release_wr_n", 32'(lcd_wr_n), 32'd1);
        w1 = wq.size();
        for (int t = 0; t < 30 && wq.size() <= w1; t++) step();
        chk("restart_write_seen", 32'(wq.size() > w1), 32'd1);
        if (wq.size() > w1)
            chk("restart_memwr", 32'(wq[w1]), 32'({1'b0, 16'h002C}));
        stream_en = 1'b0;
        repeat (20) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
